reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 135 +++++++++++++
 tb/tb_reg_file_mp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with N asynchronous read ports and M synchronous
// write ports, an optional write-to-read bypass, an optional hardwired-zero
// register 0, and a clear sequencer that zeroes the array after reset or on
// request. The storage array has no reset; the sequencer clears it instead.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset_i    asynchronous active-high reset; starts a full clear
//   clear_i    request to zero the whole array (sampled in READY only)
//   ready_o    1 = array usable, 0 = clear in progress
//   rd_addr_i  packed read addresses, port k at [k*addr_width_p +: addr_width_p]
//   rd_val_o   packed read data, port k at [k*data_width_p +: data_width_p]
//   wen_i      per-port write enable
//   w_addr_i   packed write addresses
//   w_data_i   packed write data
module reg_file_mp #(
  parameter int unsigned addr_width_p = 6,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned num_rd_p     = 3,
  parameter int unsigned num_wr_p     = 2,
  parameter int unsigned bypass_p     = 1,
  parameter int unsigned zero_reg_p   = 0
) (
  input  logic                             clk,
  input  logic                             reset_i,
  input  logic                             clear_i,
  output logic                             ready_o,
  input  logic [num_rd_p*addr_width_p-1:0] rd_addr_i,
  output logic [num_rd_p*data_width_p-1:0] rd_val_o,
  input  logic [num_wr_p-1:0]              wen_i,
  input  logic [num_wr_p*addr_width_p-1:0] w_addr_i,
  input  logic [num_wr_p*data_width_p-1:0] w_data_i
);

  localparam int unsigned depth_lp = 1 << addr_width_p;
  localparam int unsigned aw_lp    = addr_width_p;
  localparam int unsigned dw_lp    = data_width_p;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_n;
  logic [aw_lp-1:0]  clr_cnt_q, clr_cnt_n;
  logic              rd_en;

  logic [dw_lp-1:0]  rf_q [depth_lp];

  // State register and clear counter
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      clr_cnt_q <= clr_cnt_n;
    end
  end

  // Next-state logic: walk every address in CLEAR, re-enter CLEAR on request
  always_comb begin
    state_n   = state_q;
    clr_cnt_n = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_n = clr_cnt_q + aw_lp'(1);
        if (clr_cnt_q == aw_lp'(depth_lp - 1)) begin
          state_n = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_n   = ST_CLEAR;
          clr_cnt_n = '0;
        end
      end
      default: begin
        state_n   = ST_CLEAR;
        clr_cnt_n = '0;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready_o = 1'b0;
    rd_en   = 1'b0;
    if (state_q == ST_READY) begin
      ready_o = 1'b1;
      rd_en   = 1'b1;
    end
  end

  // Storage: clear sequencer owns the array in CLEAR; otherwise user writes,
  // iterated in port order so the highest-index port wins a conflict.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      rf_q[clr_cnt_q] <= '0;
    end else begin
      for (int j = 0; j < int'(num_wr_p); j++) begin
        if (wen_i[j] &&
            ((zero_reg_p == 0) || (w_addr_i[j*aw_lp +: aw_lp] != '0))) begin
          rf_q[w_addr_i[j*aw_lp +: aw_lp]] <= w_data_i[j*dw_lp +: dw_lp];
        end
      end
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write,
  // then forced to zero during clear or for the hardwired register 0.
  for (genvar k = 0; k < num_rd_p; k++) begin : g_rd
    logic [aw_lp-1:0] ra;
    logic [dw_lp-1:0] word;

    assign ra = rd_addr_i[k*aw_lp +: aw_lp];

    always_comb begin
      word = rf_q[ra];
      if (bypass_p != 0) begin
        for (int j = 0; j < int'(num_wr_p); j++) begin
          if (wen_i[j] && (w_addr_i[j*aw_lp +: aw_lp] == ra)) begin
            word = w_data_i[j*dw_lp +: dw_lp];
          end
        end
      end
      if (!rd_en || ((zero_reg_p != 0) && (ra == '0))) begin
        word = '0;
      end
    end

    assign rd_val_o[k*dw_lp +: dw_lp] = word;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Three instances share all inputs:
//   u_a: bypass off, no zero register
//   u_b: bypass on,  no zero register
//   u_c: bypass on,  hardwired zero register
// Inputs change 1 time unit after a rising edge; outputs are sampled before
// the next rising edge.
module tb_reg_file_mp;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;
  localparam int unsigned NW = 2;

  logic             clk;
  logic             reset_i;
  logic             clear_i;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] w_addr;
  logic [NW*DW-1:0] w_data;

  logic             rdy_a, rdy_b, rdy_c;
  logic [NR*DW-1:0] rv_a, rv_b, rv_c;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_mp #(.addr_width_p(AW), .data_width_p(DW), .num_rd_p(NR),
                .num_wr_p(NW), .bypass_p(0), .zero_reg_p(0)) u_a (
    .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .ready_o(rdy_a),
    .rd_addr_i(rd_addr), .rd_val_o(rv_a), .wen_i(wen),
    .w_addr_i(w_addr), .w_data_i(w_data));

  reg_file_mp #(.addr_width_p(AW), .data_width_p(DW), .num_rd_p(NR),
                .num_wr_p(NW), .bypass_p(1), .zero_reg_p(0)) u_b (
    .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .ready_o(rdy_b),
    .rd_addr_i(rd_addr), .rd_val_o(rv_b), .wen_i(wen),
    .w_addr_i(w_addr), .w_data_i(w_data));

  reg_file_mp #(.addr_width_p(AW), .data_width_p(DW), .num_rd_p(NR),
                .num_wr_p(NW), .bypass_p(1), .zero_reg_p(1)) u_c (
    .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .ready_o(rdy_c),
    .rd_addr_i(rd_addr), .rd_val_o(rv_c), .wen_i(wen),
    .w_addr_i(w_addr), .w_data_i(w_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    wen[p]            = en;
    w_addr[p*AW +: AW] = a;
    w_data[p*DW +: DW] = d;
  endtask

  // Expect ready low for 16 cycles after reset release, then high
  task automatic check_clear_after_reset(input string tag);
    check_eq({tag, "_rdy_rel"}, 32'(rdy_a), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step();
      check_eq({tag, "_rdy_low"}, 32'(rdy_a), 32'd0);
    end
    step();
    check_eq({tag, "_rdy_a_up"}, 32'(rdy_a), 32'd1);
    check_eq({tag, "_rdy_c_up"}, 32'(rdy_c), 32'd1);
  endtask

  initial begin
    reset_i = 1'b1;
    clear_i = 1'b0;
    rd_addr = '0;
    wen     = '0;
    w_addr  = '0;
    w_data  = '0;

    // Reset then clear
    #1;
    check_eq("rst_rdy", 32'(rdy_b), 32'd0);
    step();
    step();
    check_eq("rst_rd_zero", rv_b[0 +: DW], 32'd0);
    reset_i = 1'b0;
    check_eq("clr_rdy_rel", 32'(rdy_a), 32'd0);
    for (int i = 1; i < 16; i++) begin
      if (i == 5) begin
        set_wr(0, 1'b1, 4'd3, 32'h1111_1111);
        set_wr(1, 1'b1, 4'd4, 32'h2222_2222);
      end
      step();
      wen = '0;
      check_eq("clr_rdy_low", 32'(rdy_a), 32'd0);
    end
    step();
    check_eq("clr_rdy_up", 32'(rdy_a), 32'd1);
    for (int a = 0; a < 16; a++) begin
      set_rd(AW'(a), AW'(a), AW'(a));
      #1;
      check_eq("clr_zero_a", rv_a[0 +: DW], 32'd0);
    end

    // Basic and multi-port read
    set_wr(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
    set_wr(1, 1'b1, 4'd9, 32'h1234_5678);
    set_rd(4'd5, 4'd9, 4'd5);
    #1;
    check_eq("basic_old", rv_a[0 +: DW], 32'd0);
    check_eq("basic_byp", rv_b[0 +: DW], 32'hDEAD_BEEF);
    step();
    wen = '0;
    #1;
    check_eq("basic_p0", rv_a[0 +: DW], 32'hDEAD_BEEF);
    check_eq("basic_p1", rv_a[DW +: DW], 32'h1234_5678);
    check_eq("basic_p2", rv_a[2*DW +: DW], 32'hDEAD_BEEF);

    // Write conflict
    set_wr(0, 1'b1, 4'd3, 32'hAAAA_0000);
    set_wr(1, 1'b1, 4'd3, 32'h5555_FFFF);
    set_rd(4'd3, 4'd3, 4'd3);
    #1;
    check_eq("conf_old", rv_a[0 +: DW], 32'd0);
    check_eq("conf_byp", rv_b[DW +: DW], 32'h5555_FFFF);
    step();
    wen = '0;
    #1;
    check_eq("conf_a", rv_a[2*DW +: DW], 32'h5555_FFFF);
    check_eq("conf_b", rv_b[0 +: DW], 32'h5555_FFFF);

    // Bypass
    set_wr(0, 1'b1, 4'd7, 32'hCAFE_F00D);
    set_rd(4'd7, 4'd7, 4'd7);
    #1;
    check_eq("byp_same", rv_b[DW +: DW], 32'hCAFE_F00D);
    check_eq("byp_off", rv_a[DW +: DW], 32'd0);
    step();
    wen = '0;
    #1;
    check_eq("byp_next_b", rv_b[DW +: DW], 32'hCAFE_F00D);
    check_eq("byp_next_a", rv_a[DW +: DW], 32'hCAFE_F00D);

    // Zero register
    set_wr(1, 1'b1, 4'd0, 32'hFFFF_FFFF);
    set_rd(4'd0, 4'd0, 4'd0);
    #1;
    check_eq("zero_same_c", rv_c[0 +: DW], 32'd0);
    check_eq("zero_same_b", rv_b[0 +: DW], 32'hFFFF_FFFF);
    step();
    wen = '0;
    #1;
    check_eq("zero_next_c", rv_c[2*DW +: DW], 32'd0);
    check_eq("zero_next_a", rv_a[2*DW +: DW], 32'hFFFF_FFFF);

    // Fill with index values
    for (int i = 0; i < 16; i++) begin
      set_wr(0, 1'b1, AW'(i), 32'(i));
      step();
    end
    wen = '0;
    set_rd(4'd10, 4'd2, 4'd15);
    #1;
    check_eq("fill_10", rv_a[0 +: DW], 32'd10);
    check_eq("fill_15", rv_a[2*DW +: DW], 32'd15);

    // Clear request with a concurrent write to addr 2
    clear_i = 1'b1;
    set_wr(0, 1'b1, 4'd2, 32'h77);
    #1;
    check_eq("clrq_byp", rv_b[DW +: DW], 32'h77);
    step();
    clear_i = 1'b0;
    wen     = '0;
    check_eq("clrq_rdy0", 32'(rdy_a), 32'd0);
    set_rd(4'd10, 4'd10, 4'd10);
    for (int i = 1; i < 16; i++) begin
      clear_i = (i == 5);
      step();
      clear_i = 1'b0;
      check_eq("clrq_rdy_low", 32'(rdy_a), 32'd0);
      if (i == 8) check_eq("clrq_rd_forced", rv_b[0 +: DW], 32'd0);
    end
    step();
    check_eq("clrq_rdy_up", 32'(rdy_a), 32'd1);
    for (int a = 0; a < 16; a++) begin
      set_rd(AW'(a), AW'(a), AW'(a));
      #1;
      check_eq("clrq_zero_b", rv_b[DW +: DW], 32'd0);
    end

    // Reset asserted at clear cycle 8
    set_wr(0, 1'b1, 4'd9, 32'h99);
    step();
    wen = '0;
    set_rd(4'd9, 4'd9, 4'd9);
    #1;
    check_eq("mrst_pre", rv_a[0 +: DW], 32'h99);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    check_eq("mrst_mid_rdy", 32'(rdy_a), 32'd0);
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    check_clear_after_reset("mrst");
    set_rd(4'd9, 4'd15, 4'd2);
    #1;
    check_eq("mrst_rd9", rv_a[0 +: DW], 32'd0);
    check_eq("mrst_rd15", rv_a[DW +: DW], 32'd0);
    check_eq("mrst_rd2", rv_a[2*DW +: DW], 32'd0);

    // Reset takes effect without a clock edge
    #1;
    reset_i = 1'b1;
    #1;
    check_eq("async_rst_a", 32'(rdy_a), 32'd0);
    check_eq("async_rst_c", 32'(rdy_c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
